// File: rtl/atm_pkg.sv
// atm_pkg: shared definitions for the cash-terminal session controller.
//   state_t     - 3-bit session state encoding, IDLE (0) through DONE (7)
//   TIMEOUT_MAX - last inactivity count before a stalled state aborts
package atm_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LANG = 3'd1,
        ACCT = 3'd2,
        PIN  = 3'd3,
        AMT  = 3'd4,
        PROC = 3'd5,
        DISP = 3'd6,
        DONE = 3'd7
    } state_t;

    localparam logic [2:0] TIMEOUT_MAX = 3'd7;

endpackage

// File: rtl/atm.sv
// atm: session controller for a cash-dispensing terminal.
// Walks a customer through card entry, language, account type, PIN, amount,
// processing and cash collection, taking at most one step per clock.
// Ports:
//   clk             in   rising-edge clock
//   reset           in   synchronous active-high reset
//   card_insert     in   card present (level); low aborts any session
//   language        in   language selected
//   type_of_account in   account type selected
//   enter_pin       in   PIN entered/accepted
//   enter_amount    in   amount entered
//   wait_while      in   transaction processing complete
//   receive_amount  in   customer has taken the cash
//   out             out  session complete / cash dispensed (state == DONE)
//   state           out  current state code
//   count           out  inactivity counter for the current state
module atm
    import atm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       card_insert,
    input  logic       language,
    input  logic       type_of_account,
    input  logic       enter_pin,
    input  logic       enter_amount,
    input  logic       wait_while,
    input  logic       receive_amount,
    output logic       out,
    output logic [2:0] state,
    output logic [2:0] count
);

    state_t     state_q;
    logic [2:0] count_q;
    logic       advance;

    // Only the advance input belonging to the current state is looked at;
    // stale highs on the other inputs are harmless.
    always_comb begin
        advance = 1'b0;
        case (state_q)
            IDLE:    advance = card_insert;
            LANG:    advance = language;
            ACCT:    advance = type_of_account;
            PIN:     advance = enter_pin;
            AMT:     advance = enter_amount;
            PROC:    advance = wait_while;
            DISP:    advance = receive_amount;
            default: advance = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= 3'd0;
        end else if (state_q != IDLE && !card_insert) begin
            // card pulled mid-session
            state_q <= IDLE;
            count_q <= 3'd0;
        end else if (state_q == IDLE) begin
            if (advance) state_q <= LANG;
            count_q <= 3'd0;
        end else if (state_q == DONE) begin
            // hold until the card is removed
            count_q <= 3'd0;
        end else if (advance) begin
            // advance beats timeout when both coincide
            state_q <= state_t'(state_q + 3'd1);
            count_q <= 3'd0;
        end else if (count_q == TIMEOUT_MAX) begin
            state_q <= IDLE;
            count_q <= 3'd0;
        end else begin
            count_q <= count_q + 3'd1;
        end
    end

    assign state = state_q;
    assign count = count_q;
    assign out   = (state_q == DONE);

endmodule

// File: tb/tb_atm.sv
// tb_atm: directed self-checking bench for the atm session controller.
module tb_atm;

    logic       clk = 1'b0;
    logic       reset;
    logic       card_insert, language, type_of_account, enter_pin;
    logic       enter_amount, wait_while, receive_amount;
    logic       out;
    logic [2:0] state, count;

    int n_cmp = 0;
    int n_err = 0;

    // in_vec[s] is the advance input for state s (bit 0 = card_insert)
    logic [6:0] in_vec;

    always #5 clk = ~clk;

    atm dut (
        .clk             (clk),
        .reset           (reset),
        .card_insert     (card_insert),
        .language        (language),
        .type_of_account (type_of_account),
        .enter_pin       (enter_pin),
        .enter_amount    (enter_amount),
        .wait_while      (wait_while),
        .receive_amount  (receive_amount),
        .out             (out),
        .state           (state),
        .count           (count)
    );

    always_comb begin
        card_insert     = in_vec[0];
        language        = in_vec[1];
        type_of_account = in_vec[2];
        enter_pin       = in_vec[3];
        enter_amount    = in_vec[4];
        wait_while      = in_vec[5];
        receive_amount  = in_vec[6];
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // one clock edge, then settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input string tag, input logic [2:0] st,
                             input logic [2:0] cnt, input logic o);
        chk({tag, ".state"}, {5'd0, state}, {5'd0, st});
        chk({tag, ".count"}, {5'd0, count}, {5'd0, cnt});
        chk({tag, ".out"},   {7'd0, out},   {7'd0, o});
    endtask

    // reset for one edge, then walk from IDLE to target with each state's
    // advance input raised in turn (earlier ones stay high)
    task automatic go_to(input int target);
        reset  = 1'b1;
        in_vec = 7'd0;
        step();
        reset = 1'b0;
        for (int s = 0; s < target; s++) begin
            in_vec[s] = 1'b1;
            step();
        end
        chk("go_to.state", {5'd0, state}, target[7:0]);
    endtask

    initial begin
        // reset with arbitrary inputs
        reset  = 1'b1;
        in_vec = 7'b1010101;
        step();
        step();
        expect_st("reset", 3'd0, 3'd0, 1'b0);

        // happy path
        reset  = 1'b0;
        in_vec = 7'd0;
        for (int s = 0; s < 7; s++) begin
            in_vec[s] = 1'b1;
            step();
            expect_st($sformatf("happy%0d", s + 1), 3'(s + 1), 3'd0, (s == 6));
        end
        step();
        step();
        expect_st("done_hold", 3'd7, 3'd0, 1'b1);

        // card removed from DONE
        in_vec[0] = 1'b0;
        step();
        expect_st("done_card_out", 3'd0, 3'd0, 1'b0);

        // timeout in PIN
        go_to(3);
        for (int c = 1; c <= 7; c++) begin
            step();
            expect_st($sformatf("pin_wait%0d", c), 3'd3, 3'(c), 1'b0);
        end
        step();
        expect_st("pin_timeout", 3'd0, 3'd0, 1'b0);

        // advance on the count==7 edge wins over timeout
        go_to(3);
        for (int c = 1; c <= 7; c++) step();
        expect_st("pin_cnt7", 3'd3, 3'd7, 1'b0);
        in_vec[3] = 1'b1;
        step();
        expect_st("pin_adv_at7", 3'd4, 3'd0, 1'b0);

        // card removal in AMT with count 3
        go_to(4);
        step();
        step();
        step();
        expect_st("amt_cnt3", 3'd4, 3'd3, 1'b0);
        in_vec[0] = 1'b0;
        step();
        expect_st("amt_card_out", 3'd0, 3'd0, 1'b0);

        // reset mid-session dominates an advance
        go_to(5);
        in_vec[5] = 1'b1;
        reset     = 1'b1;
        step();
        expect_st("proc_reset", 3'd0, 3'd0, 1'b0);

        // stale inputs: all high through reset release, one step per cycle
        reset  = 1'b1;
        in_vec = 7'h7f;
        step();
        reset = 1'b0;
        for (int s = 1; s <= 7; s++) begin
            step();
            expect_st($sformatf("stale%0d", s), 3'(s), 3'd0, (s == 7));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
